// File: rtl/io_bus_controller_if.sv
// Request/response, DMEM and device-slot signal bundle for io_bus_controller.
// The controller takes the slave view; the load/store stage and the memory/device side take master.
interface io_bus_controller_if #(
    parameter int DBITS          = 32,
    parameter int DMEM_ADDR_BITS = 13,
    parameter int DMEMWORDBITS   = 2,
    parameter int DEV_SEL_BITS   = 3
);
    logic                                   req_valid;
    logic                                   req_ready;
    logic                                   req_we;
    logic [DBITS-1:0]                       req_addr;
    logic [DBITS-1:0]                       req_wdata;
    logic                                   rsp_valid;
    logic [DBITS-1:0]                       rsp_rdata;
    logic                                   rsp_err;
    logic [DMEM_ADDR_BITS-DMEMWORDBITS-1:0] dmem_addr;
    logic [DBITS-1:0]                       dmem_wdata;
    logic                                   dmem_we;
    logic                                   dmem_re;
    logic [DBITS-1:0]                       dmem_rdata;
    logic [DEV_SEL_BITS-1:0]                dev_sel;
    logic                                   dev_valid;
    logic                                   dev_we;
    logic [DBITS-1:0]                       dev_wdata;
    logic                                   dev_ready;
    logic [DBITS-1:0]                       dev_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, dmem_rdata, dev_ready, dev_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output dmem_addr, dmem_wdata, dmem_we, dmem_re,
        output dev_sel, dev_valid, dev_we, dev_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, dmem_rdata, dev_ready, dev_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  dmem_addr, dmem_wdata, dmem_we, dmem_re,
        input  dev_sel, dev_valid, dev_we, dev_wdata
    );
endinterface

// File: rtl/io_bus_controller.sv
// Memory-mapped I/O decoder: one outstanding load/store routed to DMEM, a device slot,
// or an error response. Every output is a register written by the single FSM block.
module io_bus_controller #(
    parameter int               DBITS          = 32,
    parameter int               DMEM_ADDR_BITS = 13,
    parameter int               DMEMWORDBITS   = 2,
    parameter int               DMEM_LAT       = 1,
    parameter logic [DBITS-1:0] IO_BASE        = 32'hf0000000,
    parameter int               NUM_DEV        = 8,
    parameter int               DEV_SEL_BITS   = 3,
    parameter int               TIMEOUT        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    io_bus_controller_if.slave bus
);
    localparam int                  CNT_BITS = $clog2(TIMEOUT + 1);
    localparam logic [DBITS:0]      IO_LO    = {1'b0, IO_BASE};
    localparam logic [DBITS:0]      IO_HI    = IO_LO + (DBITS+1)'(4 * NUM_DEV);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, MEM, DEV, RESP} stateT;

    stateT               state;
    logic                isStore;
    logic [DMEM_LAT:0]   vldPipe;
    logic [CNT_BITS-1:0] tmoCnt;

    logic                    hitMem;
    logic                    hitDev;
    logic [DEV_SEL_BITS-1:0] devSel;

    // Decode straight off the request so the strobes can be registered at the accept edge.
    always_comb begin
        hitMem = (bus.req_addr[DBITS-1:DMEM_ADDR_BITS] == '0) &&
                 (bus.req_addr[DMEMWORDBITS-1:0] == '0);
        hitDev = ({1'b0, bus.req_addr} >= IO_LO) && ({1'b0, bus.req_addr} < IO_HI) &&
                 (bus.req_addr[1:0] == 2'b00);
        devSel = DEV_SEL_BITS'((bus.req_addr - IO_BASE) >> 2);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            isStore        <= 1'b0;
            vldPipe        <= '0;
            tmoCnt         <= '0;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_err    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_re    <= 1'b0;
            bus.dev_sel    <= '0;
            bus.dev_valid  <= 1'b0;
            bus.dev_we     <= 1'b0;
            bus.dev_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        isStore       <= bus.req_we;
                        if (hitMem) begin
                            state          <= MEM;
                            bus.dmem_addr  <= bus.req_addr[DMEM_ADDR_BITS-1:DMEMWORDBITS];
                            bus.dmem_wdata <= bus.req_wdata;
                            bus.dmem_we    <= bus.req_we;
                            bus.dmem_re    <= ~bus.req_we;
                            vldPipe        <= {{DMEM_LAT{1'b0}}, ~bus.req_we};
                        end else if (hitDev) begin
                            state         <= DEV;
                            bus.dev_sel   <= devSel;
                            bus.dev_we    <= bus.req_we;
                            bus.dev_wdata <= bus.req_wdata;
                            bus.dev_valid <= 1'b1;
                            tmoCnt        <= CNT_BITS'(1);
                        end else begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                        end
                    end
                end
                MEM: begin
                    // vldPipe[k-1] marks cycle k; read data is ready to capture at the end of cycle DMEM_LAT+1.
                    bus.dmem_we <= 1'b0;
                    bus.dmem_re <= 1'b0;
                    vldPipe     <= {vldPipe[DMEM_LAT-1:0], 1'b0};
                    if (isStore) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                    end else if (vldPipe[DMEM_LAT]) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= bus.dmem_rdata;
                    end
                end
                DEV: begin
                    if (bus.dev_ready) begin
                        state         <= RESP;
                        bus.dev_valid <= 1'b0;
                        bus.dev_we    <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= isStore ? '0 : bus.dev_rdata;
                    end else if (tmoCnt == CNT_MAX) begin
                        state         <= RESP;
                        bus.dev_valid <= 1'b0;
                        bus.dev_we    <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end else begin
                        tmoCnt <= tmoCnt + 1'b1;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_rdata <= '0;
                    bus.rsp_err   <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_bus_controller.sv
// Randomized scoreboard bench for io_bus_controller with a DMEM model and a scripted device.
module tb_io_bus_controller;
    localparam int          DBITS          = 32;
    localparam int          DMEM_ADDR_BITS = 13;
    localparam int          DMEMWORDBITS   = 2;
    localparam int          DMEM_LAT       = 2;
    localparam int          NUM_DEV        = 8;
    localparam int          DEV_SEL_BITS   = 3;
    localparam int          TIMEOUT        = 16;
    localparam logic [31:0] IO_BASE        = 32'hf0000000;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } rspT;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    io_bus_controller_if #(.DBITS(DBITS), .DMEM_ADDR_BITS(DMEM_ADDR_BITS),
        .DMEMWORDBITS(DMEMWORDBITS), .DEV_SEL_BITS(DEV_SEL_BITS)) bus ();

    io_bus_controller #(.DBITS(DBITS), .DMEM_ADDR_BITS(DMEM_ADDR_BITS), .DMEMWORDBITS(DMEMWORDBITS),
        .DMEM_LAT(DMEM_LAT), .IO_BASE(IO_BASE), .NUM_DEV(NUM_DEV), .DEV_SEL_BITS(DEV_SEL_BITS),
        .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    rspT         expQ[$];
    logic [31:0] refMem [int];
    bit          outstanding = 1'b0;
    int          cyc0, kind, curIdx, curSel, devEnd;
    logic        curWe;
    logic [31:0] curWdata;
    int          accCount = 0;
    int          txnCount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] initVal(input int i);
        return (32'(i) * 32'h9e3779b1) ^ 32'h5a5a0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DMEM with DMEM_LAT cycles from read strobe to valid data; garbage otherwise.
    logic [31:0] dmemArr [0:2047];
    logic [31:0] rdPipe  [1:DMEM_LAT];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 2048; i++) dmemArr[i] <= initVal(i);
        end else if (bus.dmem_we) begin
            dmemArr[bus.dmem_addr] <= bus.dmem_wdata;
        end
        rdPipe[1] <= bus.dmem_re ? dmemArr[bus.dmem_addr] : $urandom;
        for (int i = 2; i <= DMEM_LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign bus.dmem_rdata = rdPipe[DMEM_LAT];

    // Monitor: per-cycle strobe checks for the open transaction, and scoreboard pops on rsp_valid.
    initial begin
        int  k;
        rspT e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.req_valid && bus.req_ready) accCount++;
                if (outstanding) begin
                    k = cyc - cyc0;
                    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
                    if (kind == 1) begin
                        chk("dmem_we", 32'(bus.dmem_we), 32'(curWe && k == 1));
                        chk("dmem_re", 32'(bus.dmem_re), 32'(!curWe && k == 1));
                        if (k == 1) chk("dmem_addr", 32'(bus.dmem_addr), 32'(curIdx));
                        if (k == 1 && curWe) chk("dmem_wdata", bus.dmem_wdata, curWdata);
                    end else begin
                        chk("dmem_strobe_quiet", 32'({bus.dmem_we, bus.dmem_re}), 32'd0);
                    end
                    if (kind == 2) begin
                        chk("dev_valid", 32'(bus.dev_valid), 32'(k <= devEnd));
                        if (bus.dev_valid) begin
                            chk("dev_sel", 32'(bus.dev_sel), 32'(curSel));
                            chk("dev_we", 32'(bus.dev_we), 32'(curWe));
                            if (curWe) chk("dev_wdata", bus.dev_wdata, curWdata);
                        end
                    end else begin
                        chk("dev_valid_quiet", 32'(bus.dev_valid), 32'd0);
                    end
                end
                if (bus.rsp_valid) begin
                    if (expQ.size() == 0) begin
                        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                        chk("rsp_latency", 32'(cyc - cyc0), 32'(e.lat));
                        outstanding = 1'b0;
                    end
                end else begin
                    chk("rsp_idle_zero", bus.rsp_rdata | 32'(bus.rsp_err), 32'd0);
                end
            end
        end
    end

    // Reference model: expected response from the address map, then drive the request.
    task automatic doTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [31:0] devData, input bit hold);
        rspT e;
        int  kd, idx, n, dEnd;
        bit  memHit, devHit;
        idx    = int'(addr >> 2);
        memHit = (addr < 32'h2000) && (addr % 4 == 0);
        devHit = (addr >= IO_BASE) && ({1'b0, addr} < {1'b0, IO_BASE} + 33'(4 * NUM_DEV)) &&
                 (addr % 4 == 0);
        dEnd = 0;
        if (memHit) begin
            kd = 1;
            if (we) begin
                refMem[idx] = wdata;
                e = '{1'b0, 32'h0, 2};
            end else begin
                e = '{1'b0, refMem.exists(idx) ? refMem[idx] : initVal(idx), DMEM_LAT + 2};
            end
        end else if (devHit) begin
            kd = 2;
            if (delay <= TIMEOUT) begin
                dEnd = delay;
                e = '{1'b0, we ? 32'h0 : devData, delay + 1};
            end else begin
                dEnd = TIMEOUT;
                e = '{1'b1, 32'h0, TIMEOUT + 1};
            end
        end else begin
            kd = 0;
            e = '{1'b1, 32'h0, 1};
        end
        expQ.push_back(e);

        bus.dev_ready = 1'b0;
        bus.dev_rdata = $urandom;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 50);
        if (!bus.req_ready) begin
            chk("req_accept_timeout", 32'(bus.req_ready), 32'd1);
            expQ.delete();
            bus.req_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        cyc0        = cyc - 1;
        kind        = kd;
        curWe       = we;
        curIdx      = idx & 32'h7ff;
        curSel      = int'((addr - IO_BASE) >> 2) & 7;
        curWdata    = wdata;
        devEnd      = dEnd;
        outstanding = 1'b1;
        txnCount++;
        if (!hold) bus.req_valid = 1'b0;

        if (kd == 2 && delay <= TIMEOUT) begin
            if (delay > 1) begin
                repeat (delay - 1) @(posedge clk);
                #1;
            end
            bus.dev_ready = 1'b1;
            bus.dev_rdata = devData;
            @(posedge clk); #1;
            bus.dev_ready = 1'b0;
            bus.dev_rdata = $urandom;
        end

        n = 0;
        while (outstanding && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (outstanding) begin
            chk("rsp_missing", 32'(bus.rsp_valid), 32'd1);
            outstanding = 1'b0;
            expQ.delete();
        end
        chk("req_ready_after_rsp", 32'(bus.req_ready), 32'd1);
        chk("accept_count", 32'(accCount), 32'(txnCount));
    endtask

    // Idle cycles with dev_ready toggling; the controller must ignore it outside DEV.
    task automatic idleGap(input int n);
        repeat (n) begin
            bus.dev_ready = 1'($urandom);
            bus.dev_rdata = $urandom;
            @(posedge clk); #1;
        end
        bus.dev_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.dev_ready = 1'b0;
        bus.dev_rdata = '0;
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_dmem_strobes", 32'({bus.dmem_we, bus.dmem_re}), 32'd0);
        chk("reset_dmem_addr", 32'(bus.dmem_addr), 32'd0);
        chk("reset_dev_valid", 32'(bus.dev_valid), 32'd0);
        chk("reset_dev_sel", 32'(bus.dev_sel), 32'd0);
        chk("reset_dev_we", 32'(bus.dev_we), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // DMEM store/load round trip, device load, device timeout, error decodes.
        doTxn(1'b1, 32'h00000100, 32'hdeadbeef, 1, 32'h0, 1'b0);
        doTxn(1'b0, 32'h00000100, 32'h0, 1, 32'h0, 1'b0);
        doTxn(1'b0, 32'hf0000004, 32'h0, 3, 32'h00000005, 1'b0);
        doTxn(1'b1, 32'hf000001c, 32'h12345678, TIMEOUT + 5, 32'h0, 1'b0);
        doTxn(1'b0, 32'h00002000, 32'h0, 1, 32'h0, 1'b0);
        doTxn(1'b0, 32'hf0000020, 32'h0, 1, 32'h0, 1'b0);
        doTxn(1'b0, 32'h00000102, 32'h0, 1, 32'h0, 1'b0);
        doTxn(1'b1, 32'h00001ffc, 32'hcafef00d, 1, 32'h0, 1'b0);
        doTxn(1'b0, 32'hf0000000, 32'h0, TIMEOUT, 32'habcd0123, 1'b0);
        doTxn(1'b1, 32'hf0000018, 32'h0badc0de, 1, 32'hffffffff, 1'b0);

        // req_valid held high across four back-to-back loads.
        doTxn(1'b0, 32'h00000100, 32'h0, 1, 32'h0, 1'b1);
        doTxn(1'b0, 32'h00001ffc, 32'h0, 1, 32'h0, 1'b1);
        doTxn(1'b0, 32'h00000000, 32'h0, 1, 32'h0, 1'b1);
        doTxn(1'b0, 32'h00000104, 32'h0, 1, 32'h0, 1'b0);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            int          r, dly;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: a = 32'($urandom_range(0, 63)) << 2;
                3:       a = ($urandom_range(0, 1) == 0) ? 32'h00001ffc : 32'h00002000;
                4:       a = 32'($urandom_range(0, 32'h1fff));
                5, 6, 7: a = IO_BASE + 32'(4 * $urandom_range(0, NUM_DEV - 1));
                8:       a = IO_BASE - 32'd4 + 32'($urandom_range(0, 40));
                default: a = $urandom;
            endcase
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                              : $urandom_range(1, 5);
            doTxn(1'($urandom), a, $urandom, dly, $urandom, 1'b0);
            idleGap($urandom_range(0, 3));
        end

        // Reset in cycle 2 of a device access: strobes drop, no response.
        bus.dev_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = IO_BASE + 32'd8;
        @(negedge clk);
        chk("rst_pre_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        txnCount++;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_dev_valid_before", 32'(bus.dev_valid), 32'd1);
        @(posedge clk); #1;
        chk("rst_dev_valid_dropped", 32'(bus.dev_valid), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready_in_reset", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_req_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rst_dev_valid_after", 32'(bus.dev_valid), 32'd0);
        chk("rst_accept_count", 32'(accCount), 32'(txnCount));

        // Controller must be fully usable after the mid-transaction reset.
        doTxn(1'b0, 32'h00001ffc, 32'h0, 1, 32'h0, 1'b0);
        doTxn(1'b0, 32'hf000000c, 32'h0, 2, 32'h77665544, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_bus_controller.md
Name: io_bus_controller

Overview:
- Next-generation memory-mapped I/O decoder between the processor load/store stage and data memory plus NUM_DEV UI devices (HEX, LEDR, KEY, SW, ...).
- Adds a valid/ready request channel, a registered single-cycle response pulse, configurable synchronous DMEM read latency, a per-device valid/ready handshake with timeout, and a bus-error flag for unmapped or unaligned accesses.
- One transaction is outstanding at a time.

Parameters:
- DBITS, 32, data/address width.
- DMEM_ADDR_BITS, 13, byte-address bits decoded as DMEM (0 .. 2^DMEM_ADDR_BITS-1).
- DMEMWORDBITS, 2, log2 bytes per word.
- DMEM_LAT, 1, DMEM read latency in cycles from strobe to valid dmem_rdata; minimum 1.
- IO_BASE, 32'hf0000000, byte address of device slot 0.
- NUM_DEV, 8, number of device slots, word-spaced (slot i at IO_BASE+4*i).
- DEV_SEL_BITS, 3, width of dev_sel; 2^DEV_SEL_BITS >= NUM_DEV.
- TIMEOUT, 16, maximum cycles dev_valid is held before an error response; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  DBITS  byte address.
- req_wdata  in  DBITS  store data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DBITS  load data; 0 for stores and errors.
- rsp_err  out  1  bus error, qualified by rsp_valid.
- dmem_addr  out  DMEM_ADDR_BITS-DMEMWORDBITS  DMEM word index.
- dmem_wdata  out  DBITS  DMEM write data.
- dmem_we  out  1  DMEM write strobe.
- dmem_re  out  1  DMEM read strobe.
- dmem_rdata  in  DBITS  DMEM read data.
- dev_sel  out  DEV_SEL_BITS  selected device slot.
- dev_valid  out  1  device request.
- dev_we  out  1  device write.
- dev_wdata  out  DBITS  device write data.
- dev_ready  in  1  device accepts or completes the request.
- dev_rdata  in  DBITS  device read data, valid when dev_ready=1.

Behaviour:
- **Reset.** Reset is synchronous, active-low, on clk.
  - While reset_n=0 at a rising edge: state=IDLE; all outputs 0 except req_ready=1 after the first edge; internal counters cleared.
  - Asserting reset mid-transaction drops all strobes at the next edge, discards the transaction and produces no response.
- **Acceptance.** req_ready=1 only in IDLE. A request is accepted at edge E0 when req_valid & req_ready; addr, we and wdata are registered. Cycle k means the k-th cycle after E0.
- **Decode of the registered address:**
  - DMEM if addr < 2^DMEM_ADDR_BITS and addr[DMEMWORDBITS-1:0]==0.
  - DEV if IO_BASE <= addr < IO_BASE+4*NUM_DEV and addr[1:0]==0; dev_sel=(addr-IO_BASE)>>2.
  - Anything else is ERR.
- **State machine: IDLE, MEM, DEV, RESP.**
  - IDLE -> MEM, DEV or RESP (for ERR) on acceptance.
  - MEM and DEV -> RESP when complete.
  - RESP -> IDLE unconditionally.
- **MEM.**
  - dmem_addr = addr[DMEM_ADDR_BITS-1:DMEMWORDBITS], held for the whole state.
  - dmem_we or dmem_re is high for exactly cycle 1.
  - Store: rsp_valid in cycle 2.
  - Load: dmem_rdata is registered at the end of cycle DMEM_LAT+1; rsp_valid and rsp_rdata appear in cycle DMEM_LAT+2.
- **DEV.**
  - dev_valid is high from cycle 1. dev_sel, dev_we and dev_wdata are stable while dev_valid=1.
  - If dev_ready is sampled 1 at the end of cycle k (k <= TIMEOUT): dev_valid drops in cycle k+1, and rsp_valid is asserted in cycle k+1 with rsp_rdata = dev_rdata for loads, 0 for stores.
  - If dev_ready is still 0 at the end of cycle TIMEOUT: dev_valid drops, and rsp_valid=1 with rsp_err=1 and rsp_rdata=0 in cycle TIMEOUT+1.
  - dev_ready is ignored while dev_valid=0.
- **ERR.** No DMEM or device strobe is issued. rsp_valid=1, rsp_err=1, rsp_rdata=0 in cycle 1.
- **RESP timing.** rsp_valid is high for exactly one cycle and there is no response backpressure. req_ready returns to 1 in the cycle after rsp_valid.
  - Minimum request spacing is therefore 2 cycles (ERR), 3 cycles (store) and DMEM_LAT+3 cycles (load).
- **Outputs outside their strobe.** rsp_rdata and rsp_err are 0 whenever rsp_valid=0. dmem_addr and dev_sel hold their last value. No output is ever driven to z.
- **Address boundaries.** Address 2^DMEM_ADDR_BITS-4 is DMEM. 2^DMEM_ADDR_BITS is ERR. IO_BASE+4*NUM_DEV is ERR. The timeout counter saturates and never wraps.

Test Plan:
1. DMEM_LAT=2: store 32'hdeadbeef to 0x100, then load 0x100 -> store: dmem_we=1 in cycle 1 with dmem_addr=0x40, rsp_valid in cycle 2; load: dmem_re=1 in cycle 1, rsp_valid in cycle 4 with rsp_rdata=32'hdeadbeef, rsp_err=0.
2. Load 0xf0000004 with dev_ready raised in cycle 3 and dev_rdata=32'h5 -> dev_sel=1, dev_valid high in cycles 1-3, rsp_valid in cycle 4 with rsp_rdata=5.
3. Store to 0xf000001c with dev_ready never asserted, TIMEOUT=16 -> dev_valid high in cycles 1-16, rsp_valid=1 and rsp_err=1 in cycle 17, req_ready=1 in cycle 18.
4. Load 0x00002000, 0xf0000020 and 0x00000102 (each ERR) -> no strobes, rsp_valid=1, rsp_err=1, rsp_rdata=0 in cycle 1.
5. Hold req_valid high continuously for four loads -> exactly one acceptance per transaction; req_ready=0 from E0 through the rsp_valid cycle.
6. reset_n=0 in cycle 2 of a device access -> dev_valid=0 and rsp_valid=0 after that edge, no response emitted, req_ready=1 after reset is released.
